// File: rtl/rf_access_seq.sv
// rf_access_seq -- initiator-side sequencer for a single-port register file
// whose read port has one cycle of registered latency.
//
// Operation: accept one request (src A, src B, dst, wb) and read src A, then src B.
// Present both operands to the ALU with a valid/ready handshake.
// If wb is set, wait for the result and write it to dst for one cycle.
//
// Ports:
//   CLK, RSTN             clock (rising edge), asynchronous active-low reset
//   REQ_VALID/REQ_READY   request handshake; REQ_SRC_A/REQ_SRC_B/REQ_DST/REQ_WB
//   OPS_VALID/OPS_READY   operand handshake to the ALU; OP_A/OP_B operands
//   RES_VALID/RES_READY   result handshake from the ALU; RES_DATA result
//   RF_ADDR/RF_CE/RF_WDATA/RF_RDATA  register file port (RF_CE = write enable)
//   BUSY                  sequencer is not idle
//
// Optional build macro: RF_SEQ_SAME_SRC_SKIP_EN
//   When defined and src A == src B, one read fills both operands.
//   In that case the CAP_B state is skipped and operands are ready one cycle earlier.
//
// Every output is a flop. Its next value is decoded from the next state and the
// next internal register values, so no input reaches an output combinationally.
module rf_access_seq #(
  parameter int REG_COUNT  = 4,
  parameter int DATA_WIDTH = 8,
  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [AW-1:0]         REQ_SRC_A,
  input  logic [AW-1:0]         REQ_SRC_B,
  input  logic [AW-1:0]         REQ_DST,
  input  logic                  REQ_WB,
  output logic                  OPS_VALID,
  input  logic                  OPS_READY,
  output logic [DATA_WIDTH-1:0] OP_A,
  output logic [DATA_WIDTH-1:0] OP_B,
  input  logic                  RES_VALID,
  output logic                  RES_READY,
  input  logic [DATA_WIDTH-1:0] RES_DATA,
  output logic [AW-1:0]         RF_ADDR,
  output logic                  RF_CE,
  output logic [DATA_WIDTH-1:0] RF_WDATA,
  input  logic [DATA_WIDTH-1:0] RF_RDATA,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_A     = 3'd1,
    RD_B     = 3'd2,
    CAP_B    = 3'd3,
    PRESENT  = 3'd4,
    WAIT_RES = 3'd5,
    WRITE    = 3'd6
  } state_t;

  state_t                state_q,     state_d;
  logic [AW-1:0]         src_a_q,     src_a_d;
  logic [AW-1:0]         src_b_q,     src_b_d;
  logic [AW-1:0]         dst_q,       dst_d;
  logic                  wb_q,        wb_d;
  logic [DATA_WIDTH-1:0] op_a_q,      op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q,      op_b_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [AW-1:0]         rf_addr_q,   rf_addr_d;
  logic                  rf_ce_q,     rf_ce_d;
  logic                  req_ready_q, req_ready_d;
  logic                  ops_valid_q, ops_valid_d;
  logic                  res_ready_q, res_ready_d;
  logic                  busy_q,      busy_d;

  // Next-state logic and operand/result capture.
  always_comb begin
    state_d = state_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    dst_d   = dst_q;
    wb_d    = wb_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          src_a_d = REQ_SRC_A;
          src_b_d = REQ_SRC_B;
          dst_d   = REQ_DST;
          wb_d    = REQ_WB;
          state_d = RD_A;
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        state_d = RD_B;
      end
      RD_B: begin
        // RF_RDATA now holds R[src A], because src A was addressed last cycle.
        op_a_d = RF_RDATA;
`ifdef RF_SEQ_SAME_SRC_SKIP_EN
        if (src_a_q == src_b_q) begin
          op_b_d  = RF_RDATA;
          state_d = PRESENT;
        end else begin
          state_d = CAP_B;
        end
`else
        state_d = CAP_B;
`endif
      end
      CAP_B: begin
        op_b_d  = RF_RDATA;
        state_d = PRESENT;
      end
      PRESENT: begin
        // OPS_VALID is always high in PRESENT, so OPS_READY alone completes the handshake.
        if (OPS_READY) begin
          if (wb_q) begin
            state_d = WAIT_RES;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      WAIT_RES: begin
        if (RES_VALID) begin
          wdata_d = RES_DATA;
          state_d = WRITE;
        end else begin
          state_d = WAIT_RES;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, one cycle ahead: next state and next registers give the output flop inputs.
  always_comb begin
    rf_addr_d   = {AW{1'b0}};
    rf_ce_d     = 1'b0;
    req_ready_d = 1'b0;
    ops_valid_d = 1'b0;
    res_ready_d = 1'b0;
    busy_d      = (state_d != IDLE);
    case (state_d)
      IDLE:     req_ready_d = 1'b1;
      RD_A:     rf_addr_d   = src_a_d;
      RD_B:     rf_addr_d   = src_b_d;
      CAP_B:    rf_addr_d   = {AW{1'b0}};
      PRESENT:  ops_valid_d = 1'b1;
      WAIT_RES: res_ready_d = 1'b1;
      WRITE: begin
        rf_addr_d = dst_d;
        rf_ce_d   = 1'b1;
      end
      default: begin
        rf_addr_d   = {AW{1'b0}};
        rf_ce_d     = 1'b0;
      end
    endcase
  end

  // State, internal registers and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      src_a_q     <= {AW{1'b0}};
      src_b_q     <= {AW{1'b0}};
      dst_q       <= {AW{1'b0}};
      wb_q        <= 1'b0;
      op_a_q      <= {DATA_WIDTH{1'b0}};
      op_b_q      <= {DATA_WIDTH{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      rf_addr_q   <= {AW{1'b0}};
      rf_ce_q     <= 1'b0;
      req_ready_q <= 1'b1;
      ops_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_q       <= dst_d;
      wb_q        <= wb_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      wdata_q     <= wdata_d;
      rf_addr_q   <= rf_addr_d;
      rf_ce_q     <= rf_ce_d;
      req_ready_q <= req_ready_d;
      ops_valid_q <= ops_valid_d;
      res_ready_q <= res_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign OPS_VALID = ops_valid_q;
  assign OP_A      = op_a_q;
  assign OP_B      = op_b_q;
  assign RES_READY = res_ready_q;
  assign RF_ADDR   = rf_addr_q;
  assign RF_CE     = rf_ce_q;
  assign RF_WDATA  = wdata_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_rf_access_seq.sv
// Directed testbench for rf_access_seq.
// It contains a behavioural single-port register file: reads have one cycle of
// registered latency, and writes happen when RF_CE is high.
module tb_rf_access_seq;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_SRC_A;
  logic [1:0] REQ_SRC_B;
  logic [1:0] REQ_DST;
  logic       REQ_WB;
  logic       OPS_VALID;
  logic       OPS_READY;
  logic [7:0] OP_A;
  logic [7:0] OP_B;
  logic       RES_VALID;
  logic       RES_READY;
  logic [7:0] RES_DATA;
  logic [1:0] RF_ADDR;
  logic       RF_CE;
  logic [7:0] RF_WDATA;
  logic [7:0] RF_RDATA;
  logic       BUSY;

  logic [7:0] mem [0:3];
  logic       mem_load;
  int         ce_count = 0;
  int         checks   = 0;
  int         failures = 0;

  always #5 CLK = ~CLK;

  rf_access_seq #(.REG_COUNT(4), .DATA_WIDTH(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_SRC_A(REQ_SRC_A), .REQ_SRC_B(REQ_SRC_B), .REQ_DST(REQ_DST), .REQ_WB(REQ_WB),
    .OPS_VALID(OPS_VALID), .OPS_READY(OPS_READY), .OP_A(OP_A), .OP_B(OP_B),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RF_ADDR(RF_ADDR), .RF_CE(RF_CE), .RF_WDATA(RF_WDATA), .RF_RDATA(RF_RDATA),
    .BUSY(BUSY)
  );

  // Register file model: registered read, write on RF_CE, and a count of write pulses.
  always @(posedge CLK) begin
    if (mem_load) begin
      mem[0] <= 8'd2;
      mem[1] <= 8'd3;
      mem[2] <= 8'd4;
      mem[3] <= 8'd5;
    end else begin
      RF_RDATA <= mem[RF_ADDR];
      if (RF_CE) begin
        mem[RF_ADDR] <= RF_WDATA;
        ce_count     <= ce_count + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request and advance through the accepting edge E0.
  task automatic issue(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d, input logic wb);
    REQ_SRC_A = a;
    REQ_SRC_B = b;
    REQ_DST   = d;
    REQ_WB    = wb;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
  endtask

  // Count the edges after E0 until OPS_VALID goes high. The wait is bounded.
  task automatic wait_ops(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (OPS_VALID) break;
    end
    chk(tag, n, exp_lat);
  endtask

  // Run the write-back part of an operation: handshake, result, then the WRITE cycle.
  task automatic finish_wb(input logic [7:0] res);
    OPS_READY = 1'b1;
    tick();
    OPS_READY = 1'b0;
    RES_DATA  = res;
    RES_VALID = 1'b1;
    tick();
    RES_VALID = 1'b0;
    tick();
  endtask

  int same_lat;

  initial begin
`ifdef RF_SEQ_SAME_SRC_SKIP_EN
    same_lat = 2;
`else
    same_lat = 3;
`endif
    RSTN = 1'b0; REQ_VALID = 1'b0; REQ_SRC_A = 2'd0; REQ_SRC_B = 2'd0;
    REQ_DST = 2'd0; REQ_WB = 1'b0; OPS_READY = 1'b0; RES_VALID = 1'b0;
    RES_DATA = 8'd0; mem_load = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    mem_load = 1'b0;
    chk("rst_req_ready", REQ_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_ops_valid", OPS_VALID, 0);
    chk("rst_res_ready", RES_READY, 0);
    chk("rst_rf_ce", RF_CE, 0);
    chk("rst_rf_addr", RF_ADDR, 0);
    chk("rst_rf_wdata", RF_WDATA, 0);
    chk("rst_op_a", OP_A, 0);
    chk("rst_op_b", OP_B, 0);
    #2 RSTN = 1'b1;
    tick();

    // Request A=1 B=2 dst=3 wb=1.
    issue(2'd1, 2'd2, 2'd3, 1'b1);
    chk("t1_busy", BUSY, 1);
    chk("t1_addr_a", RF_ADDR, 1);
    wait_ops(3, "t1_latency");
    chk("t1_op_a", OP_A, 8'd3);
    chk("t1_op_b", OP_B, 8'd4);
    // The ALU stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ops_valid", OPS_VALID, 1);
      chk("stall_op_a", OP_A, 8'd3);
      chk("stall_op_b", OP_B, 8'd4);
      chk("stall_req_ready", REQ_READY, 0);
      chk("stall_rf_ce", RF_CE, 0);
    end
    OPS_READY = 1'b1;
    tick();
    OPS_READY = 1'b0;
    chk("t1_res_ready", RES_READY, 1);
    chk("t1_ops_valid_low", OPS_VALID, 0);
    RES_DATA  = 8'h07;
    RES_VALID = 1'b1;
    tick();
    RES_VALID = 1'b0;
    chk("t1_wr_ce", RF_CE, 1);
    chk("t1_wr_addr", RF_ADDR, 3);
    chk("t1_wr_data", RF_WDATA, 8'h07);
    tick();
    chk("t1_ce_off", RF_CE, 0);
    chk("t1_idle_ready", REQ_READY, 1);
    chk("t1_ce_count", ce_count, 1);

    // Read R3 back (expect 7). Then restore R3 to 5, with src == dst.
    issue(2'd3, 2'd0, 2'd3, 1'b1);
    wait_ops(3, "t1b_latency");
    chk("t1b_r3_read", OP_A, 8'h07);
    chk("t1b_op_b", OP_B, 8'd2);
    finish_wb(8'd5);
    chk("t1b_ce_count", ce_count, 2);
    chk("t1b_r3_restored", mem[3], 8'd5);

    // Request with wb=0. OPS_READY is held high and RES_VALID pulses are ignored.
    OPS_READY = 1'b1;
    RES_VALID = 1'b1;
    RES_DATA  = 8'hEE;
    issue(2'd0, 2'd3, 2'd2, 1'b0);
    wait_ops(3, "t3_latency");
    chk("t3_op_a", OP_A, 8'd2);
    chk("t3_op_b", OP_B, 8'd5);
    tick();
    OPS_READY = 1'b0;
    chk("t3_idle_busy", BUSY, 0);
    chk("t3_idle_ready", REQ_READY, 1);
    chk("t3_res_ready", RES_READY, 0);
    tick();
    RES_VALID = 1'b0;
    chk("t3_op_a_kept", OP_A, 8'd2);
    chk("t3_ce_count", ce_count, 2);

    // Request with src A == src B.
    issue(2'd2, 2'd2, 2'd0, 1'b0);
    wait_ops(same_lat, "t4_latency");
    chk("t4_op_a", OP_A, 8'd4);
    chk("t4_op_b", OP_B, 8'd4);
    OPS_READY = 1'b1;
    tick();
    OPS_READY = 1'b0;
    chk("t4_idle", BUSY, 0);

    // Reset while in WAIT_RES.
    issue(2'd1, 2'd0, 2'd2, 1'b1);
    wait_ops(3, "t5_latency");
    OPS_READY = 1'b1;
    tick();
    OPS_READY = 1'b0;
    chk("t5_wait_res", RES_READY, 1);
    #2 RSTN = 1'b0;
    RES_VALID = 1'b1;
    RES_DATA  = 8'hFF;
    #1;
    chk("t5_rst_res_ready", RES_READY, 0);
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_req_ready", REQ_READY, 1);
    chk("t5_rst_op_a", OP_A, 0);
    chk("t5_rst_op_b", OP_B, 0);
    chk("t5_rst_rf_ce", RF_CE, 0);
    repeat (2) @(posedge CLK);
    #3 RSTN = 1'b1;
    RES_VALID = 1'b0;
    tick();
    chk("t5_post_ready", REQ_READY, 1);
    chk("t5_post_busy", BUSY, 0);
    chk("t5_ce_count", ce_count, 2);
    chk("t5_r2_unchanged", mem[2], 8'd4);

    // Back-to-back requests with REQ_VALID held high. Stray RES_VALID pulses are ignored.
    REQ_SRC_A = 2'd1; REQ_SRC_B = 2'd2; REQ_DST = 2'd0; REQ_WB = 1'b1;
    REQ_VALID = 1'b1;
    tick();
    RES_VALID = 1'b1;
    RES_DATA  = 8'hAA;
    chk("t6_rd_a_addr", RF_ADDR, 1);
    wait_ops(3, "t6_latency");
    tick();
    RES_VALID = 1'b0;
    chk("t6_present_hold", OPS_VALID, 1);
    chk("t6_present_ce", RF_CE, 0);
    chk("t6_op_a", OP_A, 8'd3);
    OPS_READY = 1'b1;
    tick();
    OPS_READY = 1'b0;
    RES_DATA  = 8'h09;
    RES_VALID = 1'b1;
    tick();
    RES_VALID = 1'b0;
    chk("t6_wr_ce", RF_CE, 1);
    chk("t6_wr_addr", RF_ADDR, 0);
    chk("t6_wr_data", RF_WDATA, 8'h09);
    tick();
    chk("t6_idle_ready", REQ_READY, 1);
    chk("t6_ce_count1", ce_count, 3);
    REQ_SRC_A = 2'd3; REQ_SRC_B = 2'd0; REQ_DST = 2'd1;
    tick();
    REQ_VALID = 1'b0;
    chk("t6_second_accept", BUSY, 1);
    chk("t6_second_addr", RF_ADDR, 3);
    wait_ops(3, "t6b_latency");
    chk("t6b_op_a", OP_A, 8'd5);
    chk("t6b_op_b", OP_B, 8'h09);
    finish_wb(8'h11);
    chk("t6b_ce_count", ce_count, 4);
    chk("t6b_r1", mem[1], 8'h11);
    chk("t6b_r0", mem[0], 8'h09);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_access_seq.md
Name: rf_access_seq

Overview:
- Initiator-side sequencer for the single-port register file, whose read port has 1-cycle registered latency.
- Accepts one operation request (two source addresses, one destination). Issues the two reads serially and presents both operands to the ALU with a valid/ready handshake.
- Optionally waits for the result and writes it back.
- Sits between the instruction decode/control logic and the register file.

Parameters:
- REG_COUNT, 4, number of registers in the attached register file; AW = $clog2(REG_COUNT).
- DATA_WIDTH, 8, register/operand width.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  asynchronous reset, active low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_SRC_A  in  AW  source A register address.
- REQ_SRC_B  in  AW  source B register address.
- REQ_DST  in  AW  destination register address.
- REQ_WB  in  1  1 = write the result back to REQ_DST.
- OPS_VALID  out  1  OP_A/OP_B valid.
- OPS_READY  in  1  ALU accepts operands.
- OP_A  out  DATA_WIDTH  operand A.
- OP_B  out  DATA_WIDTH  operand B.
- RES_VALID  in  1  result present.
- RES_READY  out  1  sequencer accepts result.
- RES_DATA  in  DATA_WIDTH  result to write back.
- RF_ADDR  out  AW  register file address.
- RF_CE  out  1  register file write enable.
- RF_WDATA  out  DATA_WIDTH  register file write data.
- RF_RDATA  in  DATA_WIDTH  register file registered read data.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset:
  - One clock, CLK; asynchronous active-low reset RSTN.
  - Reset forces state IDLE and clears all internal registers.
  - Reset values: OP_A=0, OP_B=0, OPS_VALID=0, RES_READY=0, RF_CE=0, RF_ADDR=0, RF_WDATA=0, BUSY=0, REQ_READY=1.
- States: IDLE, RD_A, RD_B, CAP_B, PRESENT, WAIT_RES, WRITE.
- Output decode:
  - RF_ADDR, RF_CE, RF_WDATA, REQ_READY, OPS_VALID, RES_READY and BUSY decode from state and internal registers only.
  - No combinational path from any input to any output.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY at edge E0, latch src A/B, dst and wb; go to RD_A.
- RD_A: RF_ADDR=srcA; go to RD_B.
- RD_B: RF_ADDR=srcB; RF_RDATA holds R[srcA]; at edge, op_a<=RF_RDATA; go to CAP_B.
- CAP_B: RF_ADDR=0; RF_RDATA holds R[srcB]; at edge, op_b<=RF_RDATA; go to PRESENT.
- Operand latency: OPS_VALID first high in the cycle after edge E3.
- PRESENT:
  - OPS_VALID=1; OP_A/OP_B held stable until OPS_READY.
  - On OPS_VALID&OPS_READY: go to WAIT_RES if wb=1, else IDLE.
- WAIT_RES:
  - RES_READY=1.
  - On RES_VALID: latch RES_DATA into wdata; go to WRITE.
- WRITE: RF_ADDR=dst, RF_CE=1, RF_WDATA=wdata for exactly one cycle; go to IDLE.
- Default RF_ADDR=0 in IDLE, PRESENT and WAIT_RES; RF_CE=0 in every state except WRITE.
- OP_A/OP_B keep their last captured values after the handshake; they are cleared only by reset.
- RES_VALID outside WAIT_RES is ignored. OPS_READY outside PRESENT is ignored. REQ_VALID outside IDLE is ignored; the requester holds it.
- src A == src B: two reads are still issued (no optional feature); both operands are equal.
- src == dst: operands are read before the write, so they return the pre-write value.
- Back-to-back: the next request can be accepted in the IDLE cycle right after WRITE, or right after PRESENT when wb=0.
- Reset mid-operation: the operation is abandoned, no RF_CE pulse is generated, outputs take reset values, and the sequencer is in IDLE after RSTN deasserts.
- Address widths are equal everywhere; no truncation or arithmetic is performed.

Optional Feature:
- Macro: RF_SEQ_SAME_SRC_SKIP_EN.
- Defined:
  - If the latched srcA == srcB, RD_B captures RF_RDATA into both op_a and op_b and goes directly to PRESENT, skipping CAP_B.
  - OPS_VALID is then first high after edge E2.
  - Different sources behave unchanged.
- Undefined: two reads always; latency is E3 regardless of addresses.

Test Plan:
- Reset, reg file R0..R3 = 2,3,4,5; request A=1, B=2, dst=3, wb=1 accepted at E0 -> OPS_VALID after E3 with OP_A=3, OP_B=4. Then give RES_DATA=0x07 with RES_VALID -> one-cycle RF_CE with RF_ADDR=3, RF_WDATA=0x07. A later read of R3 returns 0x07.
- Hold OPS_READY low for 5 cycles in PRESENT -> OPS_VALID stays 1, OP_A/OP_B stable, REQ_READY=0, RF_CE=0 throughout.
- Request A=0, B=3, wb=0 -> OP_A=2, OP_B=5; after the handshake, IDLE the next cycle; RF_CE never asserted; RES_VALID pulses ignored.
- Request A=B=2 -> OP_A=OP_B=4; OPS_VALID after E2 with RF_SEQ_SAME_SRC_SKIP_EN defined, after E3 without it.
- Assert RSTN low during WAIT_RES -> all outputs at reset values immediately, no RF_CE pulse; after release REQ_READY=1 and the reg file contents are unchanged by the sequencer.
- REQ_VALID held high across two requests; RES_VALID pulsed in RD_A and PRESENT (ignored) -> second request accepted in the IDLE cycle after WRITE; each request produces exactly one RF_CE pulse.
